fadd_arbiter: RTL and testbench

FADD_ARBITER -- requirements
Module: fadd_arbiter

---
 rtl/fadd_arbiter.sv | 97 +++++++++
 tb/tb_fadd_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_arbiter.sv
// Round-robin arbiter sharing one pipelined FAdd between requesters A and B; result pulses LAT+2 clocks after grant.
// Backpressure: one grant per cycle via valid/ready; results are never stalled, so requesters must take every pulse.
module fadd_arbiter #(
   parameter int LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   input  logic        b_valid,
   output logic        a_ready,
   output logic        b_ready,
   input  logic [31:0] a_in1,
   input  logic [31:0] a_in2,
   input  logic [31:0] b_in1,
   input  logic [31:0] b_in2,
   input  logic        a_op,
   input  logic        b_op,
   output logic [31:0] fa_in1,
   output logic [31:0] fa_in2,
   output logic        fa_op,
   input  logic [31:0] fa_out,
   output logic        a_res_valid,
   output logic        b_res_valid,
   output logic [31:0] a_res,
   output logic [31:0] b_res,
   output logic        idle
);

   localparam int CW = $clog2(LAT + 3);

   logic          ptr;       // 0: A has priority, 1: B has priority
   logic          hs_a;
   logic          hs_b;
   logic          hs;
   logic [LAT:0]  tag_vld;
   logic [LAT:0]  tag_id;    // 0: A, 1: B
   logic [CW-1:0] inflight;
   logic          res_pulse;

   assign a_ready   = a_valid & (~b_valid | ~ptr);
   assign b_ready   = b_valid & (~a_valid | ptr);
   assign hs_a      = a_valid & a_ready;
   assign hs_b      = b_valid & b_ready;
   assign hs        = hs_a | hs_b;
   assign res_pulse = a_res_valid | b_res_valid;
   assign idle      = ~a_valid & ~b_valid & (inflight == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr    <= 1'b0;
         fa_in1 <= '0;
         fa_in2 <= '0;
         fa_op  <= 1'b0;
      end else if (hs) begin
         ptr    <= hs_a;
         fa_in1 <= hs_b ? b_in1 : a_in1;
         fa_in2 <= hs_b ? b_in2 : a_in2;
         fa_op  <= hs_b ? b_op  : a_op;
      end
   end

   // Tags track the FAdd pipeline one stage ahead of fa_out so the last stage lines up with the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         tag_vld <= {tag_vld[LAT-1:0], hs};
         tag_id  <= {tag_id[LAT-1:0], hs_b};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_res_valid <= 1'b0;
         b_res_valid <= 1'b0;
         a_res       <= '0;
         b_res       <= '0;
      end else begin
         a_res_valid <= tag_vld[LAT] & ~tag_id[LAT];
         b_res_valid <= tag_vld[LAT] & tag_id[LAT];
         if (tag_vld[LAT] & ~tag_id[LAT]) a_res <= fa_out;
         if (tag_vld[LAT] & tag_id[LAT])  b_res <= fa_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= '0;
      end else if (hs & ~res_pulse) begin
         inflight <= inflight + CW'(1);
      end else if (~hs & res_pulse) begin
         inflight <= inflight - CW'(1);
      end
   end

endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter with a table-driven FAdd model of latency LAT.
module tb_fadd_arbiter;

   localparam int LAT = 2;

   logic        clk;
   logic        rst;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [31:0] a_in1, a_in2, b_in1, b_in2;
   logic        a_op, b_op;
   logic [31:0] fa_in1, fa_in2;
   logic        fa_op;
   logic [31:0] fa_out;
   logic        a_res_valid, b_res_valid;
   logic [31:0] a_res, b_res;
   logic        idle;

   int checks;
   int failures;

   fadd_arbiter #(.LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .b_valid(b_valid),
      .a_ready(a_ready), .b_ready(b_ready),
      .a_in1(a_in1), .a_in2(a_in2), .b_in1(b_in1), .b_in2(b_in2),
      .a_op(a_op), .b_op(b_op),
      .fa_in1(fa_in1), .fa_in2(fa_in2), .fa_op(fa_op),
      .fa_out(fa_out),
      .a_res_valid(a_res_valid), .b_res_valid(b_res_valid),
      .a_res(a_res), .b_res(b_res),
      .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed single-precision results for every operand set the bench issues.
   function automatic logic [31:0] fadd_ref(input logic [31:0] x, input logic [31:0] y, input logic op);
      if (!op && x == 32'h40000000 && y == 32'h3FE3D70A) return 32'h4071EB85;
      if (!op && x == 32'h41D26666 && y == 32'hC1D26666) return 32'h00000000;
      if ( op && x == 32'h41D26666 && y == 32'hC1D26666) return 32'h42526666;
      if (!op && x == 32'h3F800000 && y == 32'h3F800000) return 32'h40000000;
      if (!op && x == 32'h40000000 && y == 32'h3F800000) return 32'h40400000;
      if (!op && x == 32'h40400000 && y == 32'h3F800000) return 32'h40800000;
      if ( op && x == 32'h40800000 && y == 32'h3F800000) return 32'h40400000;
      if (!op && x == 32'h40A00000 && y == 32'h3F800000) return 32'h40C00000;
      if ( op && x == 32'h40A00000 && y == 32'h40000000) return 32'h40400000;
      return 32'hFFFFFFFF;
   endfunction

   logic [31:0] fpipe [LAT];
   always @(posedge clk) begin
      fpipe[0] <= fadd_ref(fa_in1, fa_in2, fa_op);
      for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
   end
   assign fa_out = fpipe[LAT-1];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic [31:0] x, input logic [31:0] y, input logic op);
      a_in1 = x; a_in2 = y; a_op = op;
   endtask

   task automatic set_b(input logic [31:0] x, input logic [31:0] y, input logic op);
      b_in1 = x; b_in2 = y; b_op = op;
   endtask

   task automatic test_reset;
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      set_a(32'h0, 32'h0, 1'b0);
      set_b(32'h0, 32'h0, 1'b0);
      tick(); tick();
      #1;
      checks++; if (fa_in1 !== 32'h0 || fa_in2 !== 32'h0 || fa_op !== 1'b0) begin
         failures++; $display("FAIL reset_fa got=%h/%h/%b exp=0/0/0", fa_in1, fa_in2, fa_op);
      end
      checks++; if (a_res !== 32'h0 || b_res !== 32'h0) begin
         failures++; $display("FAIL reset_res got=%h/%h exp=0/0", a_res, b_res);
      end
      checks++; if (a_res_valid !== 1'b0 || b_res_valid !== 1'b0) begin
         failures++; $display("FAIL reset_res_valid got=%b%b exp=00", a_res_valid, b_res_valid);
      end
      checks++; if (idle !== 1'b1) begin
         failures++; $display("FAIL reset_idle got=%b exp=1", idle);
      end
      b_valid = 1'b1;
      #1;
      checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
         failures++; $display("FAIL reset_b_only_grant got=%b%b exp=01", a_ready, b_ready);
      end
      a_valid = 1'b1;
      #1;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         failures++; $display("FAIL reset_both_grant got=%b%b exp=10", a_ready, b_ready);
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   localparam logic [31:0] RA1 [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
   localparam logic [31:0] RB1 [3] = '{32'h40800000, 32'h40A00000, 32'h40A00000};
   localparam logic [31:0] RB2 [3] = '{32'h3F800000, 32'h3F800000, 32'h40000000};
   localparam logic        RBOP [3] = '{1'b1, 1'b0, 1'b1};
   localparam logic [31:0] RRES [6] = '{32'h40000000, 32'h40400000, 32'h40400000,
                                        32'h40C00000, 32'h40800000, 32'h40400000};

   task automatic test_round_robin;
      int ai, bi;
      logic ea, eb;
      ai = 0; bi = 0;
      rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
      set_a(RA1[0], 32'h3F800000, 1'b0);
      set_b(RB1[0], RB2[0], RBOP[0]);
      tick(); tick(); tick();
      checks++; if (fa_in1 !== 32'h0) begin
         failures++; $display("FAIL rr_reset_drop got=%h exp=00000000", fa_in1);
      end
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         a_valid = (k < 6); b_valid = (k < 6);
         if (ai < 3) set_a(RA1[ai], 32'h3F800000, 1'b0);
         if (bi < 3) set_b(RB1[bi], RB2[bi], RBOP[bi]);
         #1;
         ea = (k < 6) && (k % 2 == 0);
         eb = (k < 6) && (k % 2 == 1);
         checks++; if (a_ready !== ea || b_ready !== eb) begin
            failures++; $display("FAIL rr_grant k=%0d got=%b%b exp=%b%b", k, a_ready, b_ready, ea, eb);
         end
         ea = (k >= 4) && (k <= 9) && ((k - 4) % 2 == 0);
         eb = (k >= 4) && (k <= 9) && ((k - 4) % 2 == 1);
         checks++; if (a_res_valid !== ea || b_res_valid !== eb) begin
            failures++; $display("FAIL rr_res_valid k=%0d got=%b%b exp=%b%b", k, a_res_valid, b_res_valid, ea, eb);
         end
         if (ea) begin
            checks++; if (a_res !== RRES[k-4]) begin
               failures++; $display("FAIL rr_a_res k=%0d got=%h exp=%h", k, a_res, RRES[k-4]);
            end
         end
         if (eb) begin
            checks++; if (b_res !== RRES[k-4]) begin
               failures++; $display("FAIL rr_b_res k=%0d got=%h exp=%h", k, b_res, RRES[k-4]);
            end
         end
         if ((k < 6) && (k % 2 == 0)) ai++;
         if ((k < 6) && (k % 2 == 1)) bi++;
         tick();
      end
      checks++; if (idle !== 1'b1) begin
         failures++; $display("FAIL rr_idle got=%b exp=1", idle);
      end
   endtask

   task automatic test_a_alone;
      set_a(32'h40000000, 32'h3FE3D70A, 1'b0);
      b_valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
         a_valid = (k == 0);
         #1;
         if (k == 0) begin
            checks++; if (a_ready !== 1'b1) begin
               failures++; $display("FAIL a_alone_ready got=%b exp=1", a_ready);
            end
         end
         if (k == 1) begin
            checks++; if (fa_in1 !== 32'h40000000 || fa_in2 !== 32'h3FE3D70A || fa_op !== 1'b0) begin
               failures++; $display("FAIL a_alone_fa got=%h/%h/%b exp=40000000/3fe3d70a/0", fa_in1, fa_in2, fa_op);
            end
         end
         if (k == 2) begin
            checks++; if (idle !== 1'b0) begin
               failures++; $display("FAIL a_alone_busy got=%b exp=0", idle);
            end
         end
         checks++; if (a_res_valid !== (k == 4) || b_res_valid !== 1'b0) begin
            failures++; $display("FAIL a_alone_valid k=%0d got=%b%b exp=%b0", k, a_res_valid, b_res_valid, (k == 4));
         end
         if (k >= 4) begin
            checks++; if (a_res !== 32'h4071EB85) begin
               failures++; $display("FAIL a_alone_res k=%0d got=%h exp=4071eb85", k, a_res);
            end
         end
         tick();
      end
   endtask

   task automatic test_b_alone;
      logic [31:0] eres;
      a_valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
         b_valid = (k < 2);
         set_b(32'h41D26666, 32'hC1D26666, (k == 1));
         #1;
         if (k == 2) begin
            checks++; if (fa_op !== 1'b1) begin
               failures++; $display("FAIL b_alone_fa_op got=%b exp=1", fa_op);
            end
         end
         checks++; if (b_res_valid !== (k == 4 || k == 5) || a_res_valid !== 1'b0) begin
            failures++; $display("FAIL b_alone_valid k=%0d got=%b%b exp=0%b", k, a_res_valid, b_res_valid, (k == 4 || k == 5));
         end
         if (k >= 4) begin
            eres = (k == 4) ? 32'h00000000 : 32'h42526666;
            checks++; if (b_res !== eres) begin
               failures++; $display("FAIL b_alone_res k=%0d got=%h exp=%h", k, b_res, eres);
            end
         end
         tick();
      end
   endtask

   localparam logic [31:0] BA1 [4] = '{32'h40000000, 32'h3F800000, 32'h41D26666, 32'h40A00000};
   localparam logic [31:0] BA2 [4] = '{32'h3FE3D70A, 32'h3F800000, 32'hC1D26666, 32'h3F800000};
   localparam logic        BAOP [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   localparam logic [31:0] BRES [4] = '{32'h4071EB85, 32'h40000000, 32'h42526666, 32'h40C00000};

   task automatic test_back_to_back;
      b_valid = 1'b0;
      for (int k = 0; k < 9; k++) begin
         a_valid = (k < 4);
         if (k < 4) set_a(BA1[k], BA2[k], BAOP[k]);
         #1;
         checks++; if (a_ready !== (k < 4)) begin
            failures++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, a_ready, (k < 4));
         end
         checks++; if (a_res_valid !== (k >= 4 && k <= 7) || b_res_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_valid k=%0d got=%b%b exp=%b0", k, a_res_valid, b_res_valid, (k >= 4 && k <= 7));
         end
         if (k >= 4 && k <= 7) begin
            checks++; if (a_res !== BRES[k-4]) begin
               failures++; $display("FAIL b2b_res k=%0d got=%h exp=%h", k, a_res, BRES[k-4]);
            end
         end
         if (k >= 7) begin
            checks++; if (idle !== (k == 8)) begin
               failures++; $display("FAIL b2b_idle k=%0d got=%b exp=%b", k, idle, (k == 8));
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid;
      b_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         a_valid = 1'b1;
         set_a(BA1[k], BA2[k], BAOP[k]);
         tick();
      end
      a_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (fa_in1 !== 32'h0 || fa_in2 !== 32'h0 || fa_op !== 1'b0) begin
         failures++; $display("FAIL mid_fa got=%h/%h/%b exp=0/0/0", fa_in1, fa_in2, fa_op);
      end
      checks++; if (a_res !== 32'h0 || b_res !== 32'h0) begin
         failures++; $display("FAIL mid_res got=%h/%h exp=0/0", a_res, b_res);
      end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         checks++; if (a_res_valid !== 1'b0 || b_res_valid !== 1'b0 || idle !== 1'b1) begin
            failures++; $display("FAIL mid_quiet k=%0d got=%b%b idle=%b exp=00 idle=1", k, a_res_valid, b_res_valid, idle);
         end
         tick();
      end
      a_valid = 1'b1; b_valid = 1'b1;
      #1;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         failures++; $display("FAIL mid_grant got=%b%b exp=10", a_ready, b_ready);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_round_robin();
      test_a_alone();
      test_b_alone();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
